// File: rtl/hamming_serial_encoder.sv
// Hamming (136,128) serial link transmitter.
// Accepts a 128-bit word, builds a 136-bit Hamming codeword with parity at the
// power-of-two positions, then shifts it out MSB-first after a one-cycle
// frame_start pulse. An inter-frame gap follows each frame.
// Optional feature macro: ERR_INJECT_EN (adds err_inj/err_pos single-bit error injection).
module hamming_serial_encoder #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CODE_W = 136,
    parameter int unsigned IFG    = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W:1]   din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              frame_start,
    output logic              serial_out,
    output logic              busy,
    output logic              tx_done
`ifdef ERR_INJECT_EN
    ,
    input  logic              err_inj,
    input  logic [7:0]        err_pos
`endif
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned NPAR  = 8;

    typedef enum logic [2:0] {
        IDLE,
        ENCODE,
        SYNC,
        SHIFT,
        GAP
    } state_t;

    state_t             state, state_n;
    logic [DATA_W:1]    data_q, data_n;
    logic [CODE_W:1]    cw_q, cw_n;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_n;
    logic [CNT_W-1:0]   gap_cnt, gap_cnt_n;
    logic               serial_n;
    logic               frame_start_n;
    logic               busy_n;
    logic               tx_done_n;
`ifdef ERR_INJECT_EN
    logic               err_inj_q, err_inj_n;
    logic [7:0]         err_pos_q, err_pos_n;
`endif

    // Place data in non-power-of-two positions, then derive each parity bit
    // from the data positions whose index has the matching bit set.
    function automatic logic [CODE_W:1] encode(input logic [DATA_W:1] d);
        logic [CODE_W:1] cw;
        int unsigned     j;
        logic            p;
        cw = '0;
        j  = 1;
        for (int unsigned i = 1; i <= CODE_W; i++) begin
            if ((i & (i - 1)) != 0) begin
                cw[CNT_W'(i)] = d[CNT_W'(j)];
                j++;
            end
        end
        for (int unsigned k = 0; k < NPAR; k++) begin
            p = 1'b0;
            for (int unsigned i = 1; i <= CODE_W; i++) begin
                if (((i & (i - 1)) != 0) && (((i >> k) & 1) != 0)) begin
                    p = p ^ cw[CNT_W'(i)];
                end
            end
            cw[CNT_W'(1 << k)] = p;
        end
        return cw;
    endfunction

    assign din_ready = (state == IDLE) & ~reset;

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_n       = state;
        data_n        = data_q;
        cw_n          = cw_q;
        bit_cnt_n     = bit_cnt;
        gap_cnt_n     = gap_cnt;
        serial_n      = 1'b0;
        frame_start_n = 1'b0;
        tx_done_n     = 1'b0;
`ifdef ERR_INJECT_EN
        err_inj_n     = err_inj_q;
        err_pos_n     = err_pos_q;
`endif
        case (state)
            IDLE: begin
                if (din_valid) begin
                    data_n  = din;
                    state_n = ENCODE;
`ifdef ERR_INJECT_EN
                    err_inj_n = err_inj;
                    err_pos_n = err_pos;
`endif
                end
            end
            ENCODE: begin
                cw_n = encode(data_q);
`ifdef ERR_INJECT_EN
                if (err_inj_q && (err_pos_q >= 8'd1) && (err_pos_q <= 8'(CODE_W))) begin
                    cw_n[err_pos_q] = ~cw_n[err_pos_q];
                end
`endif
                frame_start_n = 1'b1;
                state_n       = SYNC;
            end
            SYNC: begin
                bit_cnt_n = CNT_W'(CODE_W);
                serial_n  = cw_q[CODE_W];
                state_n   = SHIFT;
            end
            SHIFT: begin
                if (bit_cnt == CNT_W'(1)) begin
                    tx_done_n = 1'b1;
                    gap_cnt_n = '0;
                    state_n   = GAP;
                end else begin
                    bit_cnt_n = bit_cnt - CNT_W'(1);
                    serial_n  = cw_q[bit_cnt - CNT_W'(1)];
                end
            end
            GAP: begin
                // The IDLE cycle that follows completes the idle spacing.
                if (gap_cnt == CNT_W'(IFG - 2)) begin
                    state_n = IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            data_q      <= '0;
            cw_q        <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            serial_out  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
`ifdef ERR_INJECT_EN
            err_inj_q   <= 1'b0;
            err_pos_q   <= '0;
`endif
        end else begin
            state       <= state_n;
            data_q      <= data_n;
            cw_q        <= cw_n;
            bit_cnt     <= bit_cnt_n;
            gap_cnt     <= gap_cnt_n;
            serial_out  <= serial_n;
            frame_start <= frame_start_n;
            busy        <= busy_n;
            tx_done     <= tx_done_n;
`ifdef ERR_INJECT_EN
            err_inj_q   <= err_inj_n;
            err_pos_q   <= err_pos_n;
`endif
        end
    end

endmodule

// File: tb/tb_hamming_serial_encoder.sv
// Scoreboard bench for hamming_serial_encoder: expected codewords are queued on
// accept and compared against the deserialised stream after each frame_start.
module tb_hamming_serial_encoder;

    localparam int unsigned IFG    = 6;
    localparam int unsigned PERIOD = 138 + IFG;

    logic          clk = 1'b0;
    logic          reset;
    logic [128:1]  din;
    logic          din_valid;
    logic          din_ready;
    logic          frame_start;
    logic          serial_out;
    logic          busy;
    logic          tx_done;
`ifdef ERR_INJECT_EN
    logic          err_inj;
    logic [7:0]    err_pos;
`endif

    hamming_serial_encoder #(.IFG(IFG)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .frame_start(frame_start),
        .serial_out (serial_out),
        .busy       (busy),
        .tx_done    (tx_done)
`ifdef ERR_INJECT_EN
        ,
        .err_inj    (err_inj),
        .err_pos    (err_pos)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_pushed = 0;
    int n_rx     = 0;

    logic [136:1] exp_q[$];
    logic [7:0]   syn_q[$];

    // Monitor state
    logic         mon_on      = 1'b0;
    logic         expect_done = 1'b0;
    int           mon_bits    = 0;
    logic [136:1] rx_cw;
    logic         chk_space   = 1'b0;
    logic         fs_seen     = 1'b0;
    int           last_fs     = 0;

    task automatic check_eq(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference codeword: explicit data placement; parity vector is the XOR of
    // the indices of all set data positions.
    function automatic logic [136:1] model_cw(input logic [128:1] d);
        logic [136:1] cw;
        logic [7:0]   syn;
        cw = '0;
        syn = '0;
        cw[136:129] = d[128:121];
        cw[127:65]  = d[120:58];
        cw[63:33]   = d[57:27];
        cw[31:17]   = d[26:12];
        cw[15:9]    = d[11:5];
        cw[7:5]     = d[4:2];
        cw[3]       = d[1];
        for (int i = 1; i <= 136; i++) begin
            if (cw[8'(i)]) syn = syn ^ 8'(i);
        end
        for (int k = 0; k < 8; k++) begin
            cw[8'(1 << k)] = syn[3'(k)];
        end
        return cw;
    endfunction

    function automatic logic [7:0] syndrome(input logic [136:1] cw);
        logic [7:0] s;
        s = '0;
        for (int i = 1; i <= 136; i++) begin
            if (cw[8'(i)]) s = s ^ 8'(i);
        end
        return s;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Deserialise frames, check idle line, tx_done, spacing and scoreboard.
    always @(negedge clk) begin
        logic was_on;
        logic [136:1] e;
        logic [7:0]   es;
        if (reset) begin
            mon_on      = 1'b0;
            expect_done = 1'b0;
            exp_q.delete();
            syn_q.delete();
        end else begin
            was_on = mon_on;
            if (expect_done) begin
                check_eq("tx_done", 136'(tx_done), 136'(1));
                expect_done = 1'b0;
            end else begin
                check_eq("tx_done_idle", 136'(tx_done), 136'(0));
            end
            if (was_on) begin
                check_eq("fs_during_shift", 136'(frame_start), 136'(0));
                rx_cw[8'(mon_bits)] = serial_out;
                if (mon_bits == 1) begin
                    mon_on      = 1'b0;
                    expect_done = 1'b1;
                    n_rx++;
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_frame", 136'(1), 136'(0));
                    end else begin
                        e  = exp_q.pop_front();
                        es = syn_q.pop_front();
                        check_eq("codeword", rx_cw, e);
                        check_eq("syndrome", 136'(syndrome(rx_cw)), 136'(es));
                    end
                end else begin
                    mon_bits--;
                end
            end else begin
                check_eq("serial_idle", 136'(serial_out), 136'(0));
            end
            if (frame_start && !was_on) begin
                check_eq("busy_at_fs", 136'(busy), 136'(1));
                check_eq("ready_at_fs", 136'(din_ready), 136'(0));
                if (chk_space && fs_seen) begin
                    check_eq("fs_spacing", 136'(cyc - last_fs), 136'(PERIOD));
                end
                last_fs  = cyc;
                fs_seen  = 1'b1;
                mon_on   = 1'b1;
                mon_bits = 136;
            end
        end
    end

    // Offer a word until accepted; queue its expected codeword and syndrome.
    task automatic send(input logic [128:1] w, input logic [136:1] e, input logic [7:0] es,
                        input bit keep);
        int n;
        n = 0;
        din = w;
        din_valid = 1'b1;
        @(negedge clk);
        while (!din_ready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (!din_ready) begin
            check_eq("accept_timeout", 136'(0), 136'(1));
            din_valid = 1'b0;
        end else begin
            exp_q.push_back(e);
            syn_q.push_back(es);
            n_pushed++;
            @(posedge clk);
            #1;
            if (!keep) din_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_on || expect_done || !din_ready) && n < 3000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 3000) check_eq("idle_timeout", 136'(0), 136'(1));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [128:1] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [136:1] c;
        logic [128:1] w;
        int           n;
        reset     = 1'b1;
        din       = '0;
        din_valid = 1'b0;
`ifdef ERR_INJECT_EN
        err_inj   = 1'b0;
        err_pos   = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_serial", 136'(serial_out), 136'(0));
        check_eq("rst_fs", 136'(frame_start), 136'(0));
        check_eq("rst_busy", 136'(busy), 136'(0));
        check_eq("rst_tx_done", 136'(tx_done), 136'(0));
        check_eq("rst_ready", 136'(din_ready), 136'(1));
        @(posedge clk);
        #1;

        // Directed patterns with hand-derived codewords.
        send('0, '0, 8'd0, 1'b0);
        wait_idle();
        c = '0;
        c[3] = 1'b1; c[2] = 1'b1; c[1] = 1'b1;
        w = '0;
        w[1] = 1'b1;
        send(w, c, 8'd0, 1'b0);
        wait_idle();
        c = '0;
        c[136] = 1'b1; c[128] = 1'b1; c[8] = 1'b1;
        w = '0;
        w[128] = 1'b1;
        send(w, c, 8'd0, 1'b0);
        wait_idle();
        w = '1;
        send(w, model_cw(w), 8'd0, 1'b0);
        wait_idle();

        // Random words.
        for (int i = 0; i < 25; i++) begin
            w = rand_word();
            send(w, model_cw(w), 8'd0, 1'b0);
        end
        wait_idle();

        // din_valid held: back-to-back frames at the frame period.
        chk_space = 1'b1;
        fs_seen   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w = rand_word();
            send(w, model_cw(w), 8'd0, (i < 2));
        end
        wait_idle();
        chk_space = 1'b0;

`ifdef ERR_INJECT_EN
        begin
            logic [7:0] pos_list[6];
            pos_list = '{8'd1, 8'd5, 8'd64, 8'd136, 8'd200, 8'd0};
            for (int i = 0; i < 6; i++) begin
                w = rand_word();
                c = model_cw(w);
                err_inj = 1'b1;
                err_pos = pos_list[i];
                if (pos_list[i] >= 8'd1 && pos_list[i] <= 8'd136) begin
                    c[pos_list[i]] = ~c[pos_list[i]];
                    send(w, c, pos_list[i], 1'b0);
                end else begin
                    send(w, c, 8'd0, 1'b0);
                end
                err_inj = 1'b0;
                err_pos = '0;
            end
            wait_idle();
        end
`endif

        check_eq("frame_count", 136'(n_rx), 136'(n_pushed));

        // Reset during bit 70 of a frame aborts it.
        w = rand_word();
        send(w, model_cw(w), 8'd0, 1'b0);
        n = 0;
        while (!frame_start && n < 50) begin
            n++;
            @(negedge clk);
        end
        check_eq("abort_fs_seen", 136'(frame_start), 136'(1));
        repeat (70) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("abort_serial", 136'(serial_out), 136'(0));
        check_eq("abort_busy", 136'(busy), 136'(0));
        check_eq("abort_ready", 136'(din_ready), 136'(1));
        check_eq("abort_fs", 136'(frame_start), 136'(0));

        // Encoder still works after the abort.
        @(posedge clk);
        #1;
        w = rand_word();
        send(w, model_cw(w), 8'd0, 1'b0);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
